montgomery_param: RTL

- Parametrised interleaved Montgomery modular multiplier: result = A·B·2^-WIDTH mod M.
- Generalises the fixed 1024-bit, 2-bits-per-cycle multiplier in two ways:
  - WIDTH and digits-per-cycle are parameters.
  - Operands are registered at start, so callers need not hold them stable.
- Adds a start/busy handshake and detects an illegal even modulus.
- Sits under the exponentiation controller, which issues back-to-back multiply/square jobs.

---
 rtl/montgomery_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/montgomery_param.sv
// Interleaved Montgomery modular multiplier: result = A * B * 2^-WIDTH mod M.
// K radix-2 steps are unrolled per clock, so a job takes WIDTH/K loop cycles
// plus one final-subtraction cycle. Operands are captured when a job is accepted.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   start  - job request, accepted only while busy is low
//   in_a   - multiplier A (A < M)
//   in_b   - multiplicand B (B < M)
//   in_m   - modulus M (must be odd)
//   busy   - high from the cycle after acceptance through the done cycle
//   result - final value, held until the next job writes it
//   done   - one-cycle completion pulse
//   err    - raised with done when M was even; cleared at the next acceptance
module montgomery_param #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned K     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err
);

    localparam int unsigned N  = WIDTH / K;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCount = CW'(N - 1);

    typedef enum logic [2:0] {StIdle, StLoop, StSub, StDone, StErr} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH+1:0] c_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH+1:0] c_step;
    logic [WIDTH+1:0] c_sum;
    logic             q_bit;
    logic             a_bit;
    logic [WIDTH+1:0] c_next;
    logic [WIDTH+1:0] diff;
    logic             unused_diff_bit;

    // K chained radix-2 Montgomery steps. The sum stays below 4M, so WIDTH+2
    // bits hold it without overflow before the halving shift.
    always_comb begin
        c_step = c_q;
        c_sum  = '0;
        q_bit  = 1'b0;
        a_bit  = 1'b0;
        for (int i = 0; i < int'(K); i++) begin
            a_bit  = a_q[i];
            q_bit  = c_step[0] ^ (a_bit & b_q[0]);
            c_sum  = c_step + (a_bit ? {2'b00, b_q} : '0) + (q_bit ? {2'b00, m_q} : '0);
            c_step = c_sum >> 1;
        end
        c_next = c_step;
    end

    // Full-width subtraction; the MSB is the sign of C - M.
    assign diff            = c_q - {2'b00, m_q};
    assign unused_diff_bit = diff[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        m_q     <= in_m;
                        c_q     <= '0;
                        count_q <= '0;
                        busy    <= 1'b1;
                        if (in_m[0]) begin
                            err     <= 1'b0;
                            state_q <= StLoop;
                        end else begin
                            // Even modulus: report in the very next cycle.
                            result  <= '0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                            state_q <= StErr;
                        end
                    end
                end
                StLoop: begin
                    c_q     <= c_next;
                    a_q     <= a_q >> K;
                    count_q <= count_q + 1'b1;
                    if (count_q == LastCount) begin
                        state_q <= StSub;
                    end
                end
                StSub: begin
                    result  <= diff[WIDTH+1] ? c_q[WIDTH-1:0] : diff[WIDTH-1:0];
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone, StErr: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
